egg_timer_ctrl: RTL and testbench
=================================

Name: egg_timer_ctrl

Overview:
Control sequencer for the egg timer countdown chain. Generates the one-second tick from the system clock and issues per-digit enable strobes to the four downstream BCD digit down-counters (MM:SS). It also issues reload pulses to those counters, consumes their zero flags, and drives the run and alarm outputs. It sits directly upstream of the digit counters and downstream of the debounced button logic.

Parameters:
TICK_DIV, 100000, clk cycles per countdown tick; legal range is 2 or more.
DIV_W, 17, prescaler counter width; must satisfy 2^DIV_W >= TICK_DIV.
ALARM_TICKS, 10, ticks the alarm stays asserted before auto-return to IDLE; 0 means the alarm holds until acknowledged.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-low reset.
start_stop  in  1  single-cycle pulse from the debounced button.
clear  in  1  single-cycle pulse; abort and reload.
sec_ones_zero  in  1  zero_count from the seconds-ones digit.
sec_tens_zero  in  1  zero_count from the seconds-tens digit.
min_ones_zero  in  1  zero_count from the minutes-ones digit.
min_tens_zero  in  1  zero_count from the minutes-tens digit.
digit_load  out  1  active-high pulse; drives the reset/load input of all four digit counters.
en_sec_ones  out  1  one-cycle decrement strobe.
en_sec_tens  out  1  one-cycle decrement strobe.
en_min_ones  out  1  one-cycle decrement strobe.
en_min_tens  out  1  one-cycle decrement strobe.
running  out  1  high in RUN.
alarm  out  1  alarm drive.
state  out  2  IDLE=0, RUN=1, PAUSE=2, ALARM=3.

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE, prescaler=0, alarm tick count=0.
- While in reset: digit_load=1 and all other outputs=0. digit_load drops to 0 on the first cycle after reset deasserts.
- all_zero = AND of the four zero inputs.
- Transitions are evaluated every clk edge in this priority order: clear, then all_zero check, then start_stop.
  - clear, any state -> IDLE. digit_load=1 for exactly one cycle. Prescaler cleared. Enables suppressed that cycle.
  - IDLE + start_stop: goes to RUN if all_zero==0. If all_zero==1 the pulse is ignored and the block stays in IDLE.
  - RUN + all_zero==1 -> ALARM; alarm tick count cleared. This is checked before start_stop in the same cycle.
  - RUN + start_stop -> PAUSE.
  - PAUSE + start_stop -> RUN.
  - ALARM + start_stop -> IDLE, with a one-cycle digit_load pulse.
  - ALARM auto-return: when ALARM_TICKS!=0 and ALARM_TICKS ticks have elapsed -> IDLE, with digit_load pulse.
- Prescaler:
  - Counts 0..TICK_DIV-1, wraps to 0. An internal tick is asserted in the cycle where prescaler==TICK_DIV-1.
  - Advances only in RUN and ALARM. Held in PAUSE, so a resume keeps the partial second. Cleared in IDLE.
  - The prescaler restarts at 0 on entry to ALARM.
- Enables are registered. On a RUN tick edge, with the zero inputs sampled on that same edge, next cycle:
  - en_sec_ones=1
  - en_sec_tens=sec_ones_zero
  - en_min_ones=sec_ones_zero & sec_tens_zero
  - en_min_tens=sec_ones_zero & sec_tens_zero & min_ones_zero
- Each enable is high for exactly one cycle. No enables are issued in IDLE, PAUSE or ALARM, or if the tick coincides with clear or with the RUN->ALARM/PAUSE transition.
- Terminal count: the strobe that takes the counters to 00:00 is followed by zero flags going high one cycle later. all_zero then forces ALARM on the next edge; no further strobe is issued, so there is no wrap to 99:59.
- running=1 iff state==RUN (registered, same cycle as state).
- alarm: steady 1 in ALARM, 0 otherwise.
- Each tick in ALARM increments the alarm tick count. The count saturates at ALARM_TICKS.

Optional Feature:
ALARM_BLINK_EN. When defined, alarm starts at 1 on entry to ALARM, toggles on every tick while in ALARM, and is forced to 0 on exit. When undefined, alarm is steady 1 throughout ALARM. State and timing are otherwise identical.

Test Plan:
1. TICK_DIV=4, digits preset 00:02, reset low 3 cycles then high. Expected: digit_load=1 during reset and low on the first cycle after; state=IDLE; all enables 0.
2. start_stop pulse from 00:02. Expected: state=RUN; en_sec_ones pulses every 4 clks (one cycle wide); after 2 strobes the zero flags go high; state=ALARM one cycle later; alarm=1; no third strobe.
3. Flags sec_ones_zero=1, sec_tens_zero=1, min_ones_zero=0 at a tick (e.g. 01:00). Expected: en_sec_ones=1, en_sec_tens=1, en_min_ones=1, en_min_tens=0, all in the same cycle.
4. RUN, start_stop pulse at prescaler=2, hold 10 cycles, start_stop again. Expected: no strobes while paused; the next strobe comes 2 clks after resume.
5. ALARM_TICKS=3, enter ALARM. Expected: after 3 ticks (12 clks) state=IDLE, digit_load pulses, alarm=0. Repeat with ALARM_TICKS=0: alarm holds until start_stop, which returns to IDLE.
6. clear and start_stop in the same cycle during RUN, coincident with a tick. Expected: state=IDLE, digit_load=1 for one cycle, no enable strobe. Repeat with ALARM_BLINK_EN defined and check that alarm toggles 1,0,1 across ticks.

Source files
------------

// File: rtl/egg_timer_ctrl.sv
// rtl/egg_timer_ctrl.sv - tick prescaler and MM:SS countdown sequencer for the egg timer
// Optional feature macro: ALARM_BLINK_EN (alarm toggles once per tick while in ALARM).
module egg_timer_ctrl #(
  parameter int TICK_DIV    = 100000,
  parameter int DIV_W       = 17,
  parameter int ALARM_TICKS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       sec_ones_zero,
  input  logic       sec_tens_zero,
  input  logic       min_ones_zero,
  input  logic       min_tens_zero,
  output logic       digit_load,
  output logic       en_sec_ones,
  output logic       en_sec_tens,
  output logic       en_min_ones,
  output logic       en_min_tens,
  output logic       running,
  output logic       alarm,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ALARM = 2'd3
  } state_t;

  localparam int ACNT_W = (ALARM_TICKS < 2) ? 1 : $clog2(ALARM_TICKS + 1);
  localparam logic [DIV_W-1:0]  PRE_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [ACNT_W-1:0] ACNT_MAX = ACNT_W'(ALARM_TICKS);

  state_t              cur;
  logic [DIV_W-1:0]    pre;
  logic [ACNT_W-1:0]   acnt;
  logic                all_zero;
  logic                tick;
  logic                alarm_done;
  logic [DIV_W-1:0]    pre_next;

  assign all_zero   = sec_ones_zero & sec_tens_zero & min_ones_zero & min_tens_zero;
  assign tick       = (pre == PRE_LAST);
  assign pre_next   = tick ? '0 : pre + DIV_W'(1);
  // The tick that would bring the count to ALARM_TICKS is the one that ends ALARM.
  assign alarm_done = (ALARM_TICKS != 0) && (acnt == ACNT_MAX - ACNT_W'(1));
  assign state      = cur;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cur         <= IDLE;
      pre         <= '0;
      acnt        <= '0;
      digit_load  <= 1'b1;
      en_sec_ones <= 1'b0;
      en_sec_tens <= 1'b0;
      en_min_ones <= 1'b0;
      en_min_tens <= 1'b0;
      running     <= 1'b0;
      alarm       <= 1'b0;
    end else begin
      digit_load  <= 1'b0;
      en_sec_ones <= 1'b0;
      en_sec_tens <= 1'b0;
      en_min_ones <= 1'b0;
      en_min_tens <= 1'b0;
      if (clear) begin
        cur        <= IDLE;
        pre        <= '0;
        digit_load <= 1'b1;
        running    <= 1'b0;
        alarm      <= 1'b0;
      end else begin
        case (cur)
          IDLE: begin
            pre <= '0;
            if (start_stop && !all_zero) begin
              cur     <= RUN;
              running <= 1'b1;
            end
          end
          RUN: begin
            if (all_zero) begin
              cur     <= ALARM;
              pre     <= '0;
              acnt    <= '0;
              running <= 1'b0;
              alarm   <= 1'b1;
            end else if (start_stop) begin
              // Prescaler is held so the partial second survives the pause.
              cur     <= PAUSE;
              running <= 1'b0;
            end else begin
              pre <= pre_next;
              if (tick) begin
                en_sec_ones <= 1'b1;
                en_sec_tens <= sec_ones_zero;
                en_min_ones <= sec_ones_zero & sec_tens_zero;
                en_min_tens <= sec_ones_zero & sec_tens_zero & min_ones_zero;
              end
            end
          end
          PAUSE: begin
            if (start_stop) begin
              cur     <= RUN;
              running <= 1'b1;
            end
          end
          ALARM: begin
            if (start_stop || (tick && alarm_done)) begin
              cur        <= IDLE;
              pre        <= '0;
              digit_load <= 1'b1;
              alarm      <= 1'b0;
            end else begin
              pre <= pre_next;
              if (tick) begin
                if (acnt != ACNT_MAX) begin
                  acnt <= acnt + ACNT_W'(1);
                end
`ifdef ALARM_BLINK_EN
                alarm <= ~alarm;
`else
                alarm <= 1'b1;
`endif
              end
            end
          end
          default: begin
            cur <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_egg_timer_ctrl.sv
// tb/tb_egg_timer_ctrl.sv - randomized bench for egg_timer_ctrl against a behavioural timer model
module tb_egg_timer_ctrl;

  localparam int TICK_DIV = 4;
  localparam int DIV_W    = 2;
  localparam int AT0      = 3;
  localparam int AT1      = 0;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_ALARM = 3;

  logic clk = 1'b0;
  logic reset, start_stop, clear;
  logic [3:0] zf0, zf1;
  wire  [8:0] obs0, obs1;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Environment: the four BCD digit counters per instance, index 0=sec ones .. 3=min tens.
  int dig   [2][4];
  int dig_n [2][4];
  int pre_d [4];

  // Reference model state.
  int         m_st  [2];
  int         m_pre [2];
  int         m_acnt[2];
  bit         m_al  [2];
  logic [8:0] exp_o [2];

  always #5 clk = ~clk;

  assign zf0 = {dig[0][3] == 0, dig[0][2] == 0, dig[0][1] == 0, dig[0][0] == 0};
  assign zf1 = {dig[1][3] == 0, dig[1][2] == 0, dig[1][1] == 0, dig[1][0] == 0};

  egg_timer_ctrl #(.TICK_DIV(TICK_DIV), .DIV_W(DIV_W), .ALARM_TICKS(AT0)) u_dut0 (
    .clk(clk), .reset(reset), .start_stop(start_stop), .clear(clear),
    .sec_ones_zero(zf0[0]), .sec_tens_zero(zf0[1]),
    .min_ones_zero(zf0[2]), .min_tens_zero(zf0[3]),
    .digit_load(obs0[6]), .en_sec_ones(obs0[2]), .en_sec_tens(obs0[3]),
    .en_min_ones(obs0[4]), .en_min_tens(obs0[5]),
    .running(obs0[1]), .alarm(obs0[0]), .state(obs0[8:7])
  );

  egg_timer_ctrl #(.TICK_DIV(TICK_DIV), .DIV_W(DIV_W), .ALARM_TICKS(AT1)) u_dut1 (
    .clk(clk), .reset(reset), .start_stop(start_stop), .clear(clear),
    .sec_ones_zero(zf1[0]), .sec_tens_zero(zf1[1]),
    .min_ones_zero(zf1[2]), .min_tens_zero(zf1[3]),
    .digit_load(obs1[6]), .en_sec_ones(obs1[2]), .en_sec_tens(obs1[3]),
    .en_min_ones(obs1[4]), .en_min_tens(obs1[5]),
    .running(obs1[1]), .alarm(obs1[0]), .state(obs1[8:7])
  );

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock of the timer as described behaviourally: a second is TICK_DIV clocks of
  // RUN time, a digit borrows when every lower digit is already zero.
  task automatic model_step(input int k);
    int at, nst;
    logic [3:0] z, en;
    bit az, tk, ld, al;
    at  = (k == 0) ? AT0 : AT1;
    z   = (k == 0) ? zf0 : zf1;
    az  = &z;
    tk  = (m_pre[k] == TICK_DIV - 1);
    en  = '0;
    ld  = 1'b0;
    nst = m_st[k];
    if (!reset) begin
      nst = S_IDLE; m_pre[k] = 0; m_acnt[k] = 0; ld = 1'b1;
    end else if (clear) begin
      nst = S_IDLE; m_pre[k] = 0; ld = 1'b1;
    end else if (m_st[k] == S_IDLE) begin
      if (start_stop && !az) nst = S_RUN;
    end else if (m_st[k] == S_RUN) begin
      if (az) begin
        nst = S_ALARM; m_pre[k] = 0; m_acnt[k] = 0;
      end else if (start_stop) begin
        nst = S_PAUSE;
      end else begin
        if (tk) begin
          en[0] = 1'b1;
          for (int i = 1; i < 4; i++) en[i] = en[i-1] & z[i-1];
        end
        m_pre[k] = (m_pre[k] + 1) % TICK_DIV;
      end
    end else if (m_st[k] == S_PAUSE) begin
      if (start_stop) nst = S_RUN;
    end else begin
      if (start_stop || (tk && at != 0 && m_acnt[k] + 1 >= at)) begin
        nst = S_IDLE; m_pre[k] = 0; ld = 1'b1;
      end else begin
        m_pre[k] = (m_pre[k] + 1) % TICK_DIV;
        if (tk) begin
          m_acnt[k] = (m_acnt[k] + 1 > at) ? at : m_acnt[k] + 1;
          m_al[k]   = ~m_al[k];
        end
      end
    end
    if (nst != S_ALARM) m_al[k] = 1'b0;
    else if (m_st[k] != S_ALARM) m_al[k] = 1'b1;
`ifdef ALARM_BLINK_EN
    al = m_al[k];
`else
    al = (nst == S_ALARM);
`endif
    exp_o[k] = {2'(nst), ld, en, (nst == S_RUN), al};
    m_st[k]  = nst;
  endtask

  task automatic digits_next(input int k, input logic [8:0] o);
    for (int i = 0; i < 4; i++) begin
      if (o[6] === 1'b1) dig_n[k][i] = pre_d[i];
      else if (o[2+i] === 1'b1) dig_n[k][i] = (dig[k][i] == 0) ? ((i == 1) ? 5 : 9) : dig[k][i] - 1;
      else dig_n[k][i] = dig[k][i];
    end
  endtask

  task automatic compare(input int k);
    logic [8:0] o;
    o = (k == 0) ? obs0 : obs1;
    check_val($sformatf("c%0d_u%0d_state", cyc, k), 16'(o[8:7]), 16'(exp_o[k][8:7]));
    check_val($sformatf("c%0d_u%0d_digit_load", cyc, k), 16'(o[6]), 16'(exp_o[k][6]));
    check_val($sformatf("c%0d_u%0d_enables", cyc, k), 16'(o[5:2]), 16'(exp_o[k][5:2]));
    check_val($sformatf("c%0d_u%0d_running", cyc, k), 16'(o[1]), 16'(exp_o[k][1]));
    check_val($sformatf("c%0d_u%0d_alarm", cyc, k), 16'(o[0]), 16'(exp_o[k][0]));
  endtask

  task automatic cycle(input bit rs, input bit ss, input bit cl);
    reset = rs; start_stop = ss; clear = cl;
    for (int k = 0; k < 2; k++) begin
      model_step(k);
      digits_next(k, (k == 0) ? obs0 : obs1);
    end
    @(posedge clk);
    #1;
    dig = dig_n;
    @(negedge clk);
    for (int k = 0; k < 2; k++) compare(k);
    cyc++;
  endtask

  initial begin
    pre_d = '{2, 0, 0, 0};
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) dig[k][i] = pre_d[i];
      m_st[k] = S_IDLE; m_pre[k] = 0; m_acnt[k] = 0; m_al[k] = 1'b0;
    end
    reset = 1'b0; start_stop = 1'b0; clear = 1'b0;

    // Reset, then count 00:02 down to alarm; unit 0 auto-returns, unit 1 holds.
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    repeat (3) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    repeat (30) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    repeat (6) cycle(1'b1, 1'b0, 1'b0);

    // Pause part way through a second and resume.
    cycle(1'b1, 1'b1, 1'b0);
    repeat (10) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    repeat (8) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1);
    repeat (3) cycle(1'b1, 1'b0, 1'b0);

    // 01:00 exercises the multi-digit borrow pattern.
    pre_d = '{0, 0, 1, 0};
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    repeat (12) cycle(1'b1, 1'b0, 1'b0);

    for (int seg = 0; seg < 8; seg++) begin
      pre_d = '{int'($urandom_range(0, 9)), int'($urandom_range(0, 1)),
                int'($urandom_range(0, 1)), 0};
      cycle(1'b1, 1'b0, 1'b1);
      repeat (2000) cycle($urandom_range(0, 999) != 0,
                          $urandom_range(0, 39) == 0,
                          $urandom_range(0, 149) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
